sorted_vector_serializer: RTL and testbench

Converts a full parallel vector (`NUMBERS_AMOUNT` × `NUMBER_WIDTH`, as produced by `sorting_network`) into a stream of single numbers with a valid/ready handshake. It sits directly on the sorter's output. The sorter has no backpressure, so the block holds two vectors in a ping-pong buffer. Vectors arriving while both slots are occupied are dropped and flagged.

---
 rtl/sorted_vector_serializer.sv | 118 +++++++++++
 tb/tb_sorted_vector_serializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sorted_vector_serializer.sv
// sorted_vector_serializer
// Turns a full parallel vector from the sorting network into a stream of
// single numbers with a valid/ready handshake. The source has no
// backpressure, so two vector slots form a ping-pong buffer. A vector that
// arrives while both slots are occupied is dropped and flagged.
module sorted_vector_serializer #(
  parameter int NUMBER_WIDTH    = 10,
  parameter int NUMBERS_AMOUNT  = 10,
  parameter bit EMIT_DESCENDING = 1'b0,
  parameter int IDX_W           = (NUMBERS_AMOUNT > 1) ? $clog2(NUMBERS_AMOUNT) : 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] data_i,
  input  logic                                        data_valid_i,
  output logic [NUMBER_WIDTH-1:0]                     num_o,
  output logic [IDX_W-1:0]                            num_idx_o,
  output logic                                        num_valid_o,
  input  logic                                        num_ready_i,
  output logic                                        num_last_o,
  output logic                                        overflow_o,
  output logic                                        busy_o
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUMBERS_AMOUNT - 1);

  occ_e                                        r_occ;
  logic [IDX_W-1:0]                            r_beat;
  logic                                        r_wr_sel;
  logic                                        r_rd_sel;
  logic                                        r_overflow;
  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] r_slot [2];

  occ_e             w_occ_next;
  logic             w_valid;
  logic             w_last;
  logic             w_fire;
  logic             w_final_fire;
  logic             w_capture;
  logic             w_drop;
  logic [IDX_W-1:0] w_elem_idx;

  assign w_valid      = (r_occ != OCC_EMPTY);
  assign w_last       = w_valid && (r_beat == LAST_BEAT);
  assign w_fire       = w_valid && num_ready_i;
  assign w_final_fire = w_fire && w_last;
  // A full buffer can still take a vector when the final beat frees a slot
  // in the same cycle; otherwise the vector is lost.
  assign w_capture    = data_valid_i && ((r_occ != OCC_FULL) || w_final_fire);
  assign w_drop       = data_valid_i && (r_occ == OCC_FULL) && !w_final_fire;

  // Descending mode walks the slot from the top; num_idx_o stays in emit order.
  assign w_elem_idx   = EMIT_DESCENDING ? (LAST_BEAT - r_beat) : r_beat;

  assign num_valid_o  = w_valid;
  assign num_last_o   = w_last;
  assign num_idx_o    = r_beat;
  assign num_o        = r_slot[r_rd_sel][w_elem_idx];
  assign busy_o       = w_valid;
  assign overflow_o   = r_overflow;

  // Occupancy next state: +1 on capture, -1 on final fire, both cancel.
  always_comb begin
    // NOTE: the next state gets a default first so that every path assigns it
    // and no latch is inferred.
    w_occ_next = r_occ;
    if (w_capture && !w_final_fire) begin
      unique case (r_occ)
        OCC_EMPTY: w_occ_next = OCC_ONE;
        OCC_ONE:   w_occ_next = OCC_FULL;
        default:   w_occ_next = r_occ;
      endcase
    end else if (w_final_fire && !w_capture) begin
      unique case (r_occ)
        OCC_FULL: w_occ_next = OCC_ONE;
        OCC_ONE:  w_occ_next = OCC_EMPTY;
        default:  w_occ_next = r_occ;
      endcase
    end
  end

  // State register, slot writes, beat/read pointer advance and overflow pulse.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      r_occ      <= OCC_EMPTY;
      r_beat     <= '0;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_overflow <= 1'b0;
      // NOTE: the slots are reset too, so num_o reads 0 after reset rather
      // than stale data; this is what keeps storage out of plain RAM.
      r_slot[0]  <= '0;
      r_slot[1]  <= '0;
    end else begin
      r_occ      <= w_occ_next;
      r_overflow <= w_drop;
      if (w_capture) begin
        r_slot[r_wr_sel] <= data_i;
        r_wr_sel         <= ~r_wr_sel;
      end
      if (w_final_fire) begin
        r_beat   <= '0;
        r_rd_sel <= ~r_rd_sel;
      end else if (w_fire) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sorted_vector_serializer.sv
// Directed bench for sorted_vector_serializer with default parameters
// (10 numbers of 10 bits, ascending emit order).
module tb_sorted_vector_serializer;

  localparam int W = 10;
  localparam int N = 10;
  localparam int IW = 4;

  typedef logic [N-1:0][W-1:0] vec_t;

  typedef struct {
    logic dv;
    int   base;
    int   step;
    logic rdy;
    logic ev;
    int   en;
    int   ei;
    logic el;
    logic eo;
    logic eb;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  vec_t          data_i = '0;
  logic          data_valid_i = 1'b0;
  logic [W-1:0]  num_o;
  logic [IW-1:0] num_idx_o;
  logic          num_valid_o;
  logic          num_ready_i = 1'b0;
  logic          num_last_o;
  logic          overflow_o;
  logic          busy_o;

  int   total = 0;
  int   bad   = 0;
  rec_t tbl[$];

  sorted_vector_serializer #(
    .NUMBER_WIDTH   (W),
    .NUMBERS_AMOUNT (N),
    .EMIT_DESCENDING(1'b0)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .data_valid_i(data_valid_i),
    .num_o       (num_o),
    .num_idx_o   (num_idx_o),
    .num_valid_o (num_valid_o),
    .num_ready_i (num_ready_i),
    .num_last_o  (num_last_o),
    .overflow_o  (overflow_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t make_vec(input int base, input int step);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = W'(base + step * i);
    return v;
  endfunction

  function automatic void add(input logic dv, input int base, input int step,
                              input logic rdy, input logic ev, input int en,
                              input int ei, input logic el, input logic eo,
                              input logic eb);
    rec_t r;
    r.dv = dv; r.base = base; r.step = step; r.rdy = rdy;
    r.ev = ev; r.en = en; r.ei = ei; r.el = el; r.eo = eo; r.eb = eb;
    tbl.push_back(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ev, input int en, input int ei,
                           input logic el, input logic eo, input logic eb);
    check({tag, ".valid"}, 32'(num_valid_o), 32'(ev));
    if (ev) check({tag, ".num"}, 32'(num_o), 32'(en));
    check({tag, ".idx"}, 32'(num_idx_o), 32'(ei));
    check({tag, ".last"}, 32'(num_last_o), 32'(el));
    check({tag, ".ovf"}, 32'(overflow_o), 32'(eo));
    check({tag, ".busy"}, 32'(busy_o), 32'(eb));
  endtask

  initial begin
    int fires;
    bit done;

    // Test 1: reset then idle.
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_out($sformatf("t1.idle%0d", k), 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      check($sformatf("t1.num%0d", k), 32'(num_o), 32'd0);
    end

    // Test 2: single vector 9..0 with ready held high.
    add(1'b1, 9, -1, 1'b1, 1'b1, 9, 0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k < 10; k++)
      add(1'b0, 0, 0, 1'b1, 1'b1, 9 - k, k, (k == 9), 1'b0, 1'b1);
    add(1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    // Test 4: vectors A and B back to back, 20 contiguous beats.
    add(1'b1, 0, 1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 100, 1, 1'b1, 1'b1, 1, 1, 1'b0, 1'b0, 1'b1);
    for (int k = 2; k < 10; k++)
      add(1'b0, 0, 0, 1'b1, 1'b1, k, k, (k == 9), 1'b0, 1'b1);
    for (int k = 10; k < 20; k++)
      add(1'b0, 0, 0, 1'b1, 1'b1, 100 + k - 10, k - 10, (k == 19), 1'b0, 1'b1);
    add(1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      data_valid_i = tbl[i].dv;
      data_i       = tbl[i].dv ? make_vec(tbl[i].base, tbl[i].step) : '0;
      num_ready_i  = tbl[i].rdy;
      tick();
      check_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].en, tbl[i].ei,
                tbl[i].el, tbl[i].eo, tbl[i].eb);
    end
    data_valid_i = 1'b0;

    // Test 3: ready toggling 1,0,1,0; stalled cycles must hold the beat.
    num_ready_i  = 1'b0;
    data_valid_i = 1'b1;
    data_i       = make_vec(9, -1);
    tick();
    data_valid_i = 1'b0;
    fires = 0;
    done  = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      num_ready_i = (cyc % 2 == 0);
      if (num_valid_o && num_ready_i) begin
        check($sformatf("t3.num%0d", fires), 32'(num_o), 32'(9 - fires));
        check($sformatf("t3.idx%0d", fires), 32'(num_idx_o), 32'(fires));
        check($sformatf("t3.last%0d", fires), 32'(num_last_o), 32'(fires == 9));
        fires++;
      end
      tick();
      if (!busy_o) begin
        done = 1'b1;
      end else if (!num_ready_i) begin
        check($sformatf("t3.stall_num%0d", cyc), 32'(num_o), 32'(9 - fires));
        check($sformatf("t3.stall_idx%0d", cyc), 32'(num_idx_o), 32'(fires));
        check($sformatf("t3.stall_last%0d", cyc), 32'(num_last_o), 32'(fires == 9));
      end
    end
    check("t3.fires", 32'(fires), 32'd10);
    check("t3.drained", 32'(done), 32'd1);

    // Test 5: fill both slots with ready low, drop C, then accept D on A's
    // final fire.
    num_ready_i  = 1'b0;
    data_valid_i = 1'b1;
    data_i       = make_vec(0, 1);
    tick();
    data_i       = make_vec(100, 1);
    tick();
    check_out("t5.full", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
    data_i       = make_vec(200, 1);
    tick();
    data_valid_i = 1'b0;
    check_out("t5.drop", 1'b1, 0, 0, 1'b0, 1'b1, 1'b1);
    tick();
    check_out("t5.after_drop", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
    num_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check_out($sformatf("t5.A%0d", k), 1'b1, k, k, (k == 9), 1'b0, 1'b1);
      if (k == 9) begin
        data_valid_i = 1'b1;
        data_i       = make_vec(300, 1);
      end
      tick();
      data_valid_i = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      check_out($sformatf("t5.B%0d", k), 1'b1, 100 + k, k, (k == 9), 1'b0, 1'b1);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      check_out($sformatf("t5.D%0d", k), 1'b1, 300 + k, k, (k == 9), 1'b0, 1'b1);
      tick();
    end
    check_out("t5.empty", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Test 6: reset at beat 4 abandons the vector; data_valid_i is ignored
    // during reset; a fresh vector then streams from beat 0.
    data_valid_i = 1'b1;
    data_i       = make_vec(0, 1);
    tick();
    data_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check_out("t6.beat4", 1'b1, 4, 4, 1'b0, 1'b0, 1'b1);
    rst_i        = 1'b1;
    data_valid_i = 1'b1;
    data_i       = make_vec(200, 1);
    tick();
    rst_i        = 1'b0;
    data_valid_i = 1'b0;
    check_out("t6.rst", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    check("t6.rst_num", 32'(num_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out($sformatf("t6.idle%0d", k), 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    end
    data_valid_i = 1'b1;
    data_i       = make_vec(100, 1);
    tick();
    data_valid_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check_out($sformatf("t6.B%0d", k), 1'b1, 100 + k, k, (k == 9), 1'b0, 1'b1);
      tick();
    end
    check_out("t6.empty", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
